hilo_muldiv: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO registers for the MIPS core. It consumes the two source operands read from the register file (rs, rt) for MULT, MULTU, DIV and DIVU. It produces a 64-bit result in HI/LO over a fixed 33-cycle run, and it exposes HI/LO to the MFHI/MFLO writeback path. It also accepts MTHI/MTLO writes from the same operand bus.

---
 rtl/hilo_muldiv.sv | 207 ++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32x32 multiply / 32/32 divide unit that owns the
// architectural HI/LO registers. One operation takes 33 cycles: 32 RUN
// iterations over unsigned magnitudes followed by a FIX cycle that applies
// the latched signs and writes HI/LO.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [5:0] count;
    logic       accept;

    // Operands viewed as two's-complement for the signed ops.
    logic signed [31:0] rs_signed;
    logic signed [31:0] rt_signed;

    // Latched operation context.
    logic        op_div;     // 1: divide, 0: multiply
    logic        neg_qp;     // negate product / quotient in FIX
    logic        neg_rem;    // negate remainder in FIX
    logic        div_zero;   // divisor was zero
    logic [31:0] opnd;       // multiplicand magnitude or divisor magnitude

    // Shared iteration registers.
    // Multiply: {acc_hi, acc_lo} is the shifting product, acc_lo starts
    // as the multiplier magnitude.
    // Divide: acc_hi is the partial remainder, acc_lo starts as the
    // dividend magnitude and fills with quotient bits from the right.
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    // Per-iteration combinational terms.
    logic [31:0] addend;
    logic [32:0] add_sum;
    logic [32:0] shift_rem;
    logic        sub_ok;
    logic [31:0] sub_diff;

    // Results presented to HI/LO in the FIX cycle.
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Absolute value for signed ops; raw value for unsigned ops.
    // The most negative value maps onto 0x80000000, which is its
    // correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic signed [31:0] v,
                                              input logic is_signed);
        logic [31:0] m;
        if (is_signed && (v < 0)) begin
            m = 32'(-v);
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Conditional two's-complement negation, 32-bit.
    function automatic logic [31:0] apply_sign32(input logic [31:0] v,
                                                 input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Conditional two's-complement negation, 64-bit.
    function automatic logic [63:0] apply_sign64(input logic [63:0] v,
                                                 input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    assign rs_signed = rs_data;
    assign rt_signed = rt_data;
    assign accept    = (state == IDLE) && start;
    assign busy      = (state != IDLE);

    // Control registers: state, iteration counter and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= 6'd0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == FIX);
            if (accept) begin
                count <= 6'd0;
            end else if (state == RUN) begin
                count <= count + 6'd1;
            end
        end
    end

    // Next-state logic: fixed 32 RUN iterations then one FIX cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (count == 6'd31) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // One shift-add step and one restoring-divide step, both unsigned.
    always_comb begin
        addend    = acc_lo[0] ? opnd : 32'd0;
        add_sum   = {1'b0, acc_hi} + {1'b0, addend};
        shift_rem = {acc_hi, acc_lo[31]};
        sub_ok    = (shift_rem >= {1'b0, opnd});
        sub_diff  = shift_rem[31:0] - opnd;
    end

    // Sign fix-up and result selection for the FIX cycle.
    // A zero divisor yields all-ones quotient bits and leaves the dividend
    // magnitude as remainder; re-applying the dividend sign restores the
    // raw rs value, so only the quotient needs forcing.
    always_comb begin
        prod = apply_sign64({acc_hi, acc_lo}, neg_qp);
        quo  = div_zero ? 32'hFFFF_FFFF : apply_sign32(acc_lo, neg_qp);
        rem  = apply_sign32(acc_hi, neg_rem);
        if (op_div) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    // Datapath: latch operands on accept, iterate one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_div   <= op[1];
            neg_qp   <= ~op[0] & (rs_data[31] ^ rt_data[31]);
            neg_rem  <= ~op[0] & rs_data[31];
            div_zero <= op[1] & (rt_data == 32'd0);
            acc_hi   <= 32'd0;
            if (op[1]) begin
                opnd   <= magnitude(rt_signed, ~op[0]);
                acc_lo <= magnitude(rs_signed, ~op[0]);
            end else begin
                opnd   <= magnitude(rs_signed, ~op[0]);
                acc_lo <= magnitude(rt_signed, ~op[0]);
            end
        end else if (state == RUN) begin
            if (op_div) begin
                acc_hi <= sub_ok ? sub_diff : shift_rem[31:0];
                acc_lo <= {acc_lo[30:0], sub_ok};
            end else begin
                acc_hi <= add_sum[32:1];
                acc_lo <= {add_sum[0], acc_lo[31:1]};
            end
        end
    end

    // HI/LO: operation results in FIX, move-to writes only in a quiet IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == FIX) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if ((state == IDLE) && !start) begin
            if (mthi) begin
                hi <= wr_data;
            end
            if (mtlo) begin
                lo <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed testbench for hilo_muldiv: hand-computed MULT/DIV results,
// divide-by-zero and overflow corners, move-to writes, start collisions,
// back-to-back issue and mid-operation reset.
module tb_hilo_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    hilo_muldiv dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Caller is at a negedge; drives a start for one edge and returns at
    // the negedge after the accepting edge E0.
    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic mh,
                          input logic ml, input logic [31:0] wd);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        mthi    = mh;
        mtlo    = ml;
        wr_data = wd;
        @(negedge clk);
        start   = 1'b0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        op      = 2'b10;
        rs_data = 32'h5A5A_5A5A;
        rt_data = 32'hA5A5_A5A5;
        wr_data = 32'h0;
    endtask

    // Counts busy negedges starting at the current one (bounded), noting
    // any done seen while still busy. Returns at the first negedge with busy=0.
    task automatic wait_done(output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        while ((busy === 1'b1) && (cycles < 40)) begin
            cycles++;
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh,
                         input logic [31:0] el, input string tag);
        int cyc;
        int dn;
        launch(o, a, b, 1'b0, 1'b0, 32'd0);
        wait_done(cyc, dn);
        check({tag, "_busy_cycles"}, 64'(cyc), 64'd33);
        check({tag, "_early_done"}, 64'(dn), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int dn;

        rst     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = 32'd0;
        rt_data = 32'd0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        wr_data = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        // Largest unsigned product, and single-cycle done pulse.
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        check("multu_max_done_drop", 64'(done), 64'd0);

        // Signed multiply and divide, including sign of remainder.
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2");
        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, "divu_big");

        // Divide by zero: quotient all ones, HI gets the raw dividend.
        do_op(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, "divu_by0");
        do_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_neg_by0");

        // Signed overflow corner.
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_ovf");

        // mthi alone, then mthi+mtlo together, in IDLE.
        mthi    = 1'b1;
        wr_data = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(lo), 64'h8000_0000);
        mthi    = 1'b1;
        mtlo    = 1'b1;
        wr_data = 32'h0BAD_F00D;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_hi", 64'(hi), 64'h0BAD_F00D);
        check("mthilo_lo", 64'(lo), 64'h0BAD_F00D);

        // mtlo while busy is ignored.
        launch(OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        mtlo    = 1'b1;
        wr_data = 32'hAAAA_5555;
        @(negedge clk);
        mtlo = 1'b0;
        check("mtlo_busy_lo", 64'(lo), 64'h0BAD_F00D);
        wait_done(cyc, dn);
        check("mtlo_busy_cycles", 64'(cyc), 64'd31);
        check("mtlo_busy_done", 64'(done), 64'd1);
        check("mtlo_busy_res_lo", 64'(lo), 64'd15);
        check("mtlo_busy_res_hi", 64'(hi), 64'd0);
        @(negedge clk);

        // start together with mthi: start wins.
        launch(OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b0, 32'hCAFE_F00D);
        check("start_mthi_hi_kept", 64'(hi), 64'd0);
        wait_done(cyc, dn);
        check("start_mthi_cycles", 64'(cyc), 64'd33);
        check("start_mthi_hi", 64'(hi), 64'd0);
        check("start_mthi_lo", 64'(lo), 64'd42);
        @(negedge clk);

        // Second start mid-operation is ignored and not queued.
        launch(OP_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0, 32'd0);
        repeat (5) @(negedge clk);
        start   = 1'b1;
        op      = OP_MULTU;
        rs_data = 32'd5;
        rt_data = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, dn);
        check("restart_cycles", 64'(cyc), 64'd27);
        check("restart_early_done", 64'(dn), 64'd0);
        check("restart_done", 64'(done), 64'd1);
        check("restart_hi", 64'(hi), 64'd6);
        check("restart_lo", 64'(lo), 64'd142);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dn++;
        end
        check("restart_not_queued", 64'(dn), 64'd0);

        // Back-to-back: new start during the done cycle.
        launch(OP_MULT, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        wait_done(cyc, dn);
        check("b2b_first_cycles", 64'(cyc), 64'd33);
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_hi", 64'(hi), 64'd0);
        check("b2b_first_lo", 64'(lo), 64'h8000_0000);
        launch(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 32'd0);
        check("b2b_done_drop", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(cyc, dn);
        check("b2b_second_cycles", 64'(cyc), 64'd33);
        check("b2b_second_done", 64'(done), 64'd1);
        check("b2b_second_hi", 64'(hi), 64'h0000_000F);
        check("b2b_second_lo", 64'(lo), 64'h0FFF_FFFF);
        @(negedge clk);

        // Reset at RUN counter 10 aborts without a done pulse.
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        do_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
